// File: rtl/oled_spi_receiver.sv
// oled_spi_receiver: display-side SPI deserialiser with D/C decode, display-on tracking and word counters
module oled_spi_receiver #(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             i_CS,
  input  logic             i_MOSI,
  input  logic             i_SCK,
  input  logic             i_DC,
  input  logic             i_RES,
  output logic [N-1:0]     o_DATA,
  output logic             o_DC,
  output logic             o_VALID,
  output logic             o_FRAME_ERR,
  output logic             o_DISPLAY_ON,
  output logic [CNT_W-1:0] o_CMD_COUNT,
  output logic [CNT_W-1:0] o_DATA_COUNT
);
  localparam int BW = $clog2(N);
  localparam logic [BW-1:0] LAST = BW'(N - 1);
  localparam logic [N-1:0] ON = N'(8'hAF);
  localparam logic [N-1:0] OFF = N'(8'hAE);
  typedef enum logic [1:0] {IDLE, SHIFT, HELD} state_t;
  state_t state;
  logic [1:0] cs_s, mosi_s, dc_s, res_s;
  logic [2:0] sck_s;
  logic cs_d, cs, sck_rise, last;
  logic [N-2:0] shreg;
  logic [N-1:0] word;
  logic [BW-1:0] bit_cnt, nxt_cnt;
  assign cs = cs_s[1];
  assign sck_rise = sck_s[1] & ~sck_s[2];
  assign word = {shreg, mosi_s[1]};
  assign last = sck_rise && bit_cnt == LAST;
  // bit count after this cycle's edge is taken; a nonzero value at CS rise means a partial word
  assign nxt_cnt = last ? '0 : sck_rise ? bit_cnt + BW'(1) : bit_cnt;
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      cs_s <= 2'b11;
      sck_s <= 3'b111;
      res_s <= 2'b11;
      mosi_s <= 2'b00;
      dc_s <= 2'b00;
      cs_d <= 1'b1;
      state <= IDLE;
      bit_cnt <= '0;
      shreg <= '0;
      o_DATA <= '0;
      o_DC <= 1'b0;
      o_VALID <= 1'b0;
      o_FRAME_ERR <= 1'b0;
      o_DISPLAY_ON <= 1'b0;
      o_CMD_COUNT <= '0;
      o_DATA_COUNT <= '0;
    end else begin
      cs_s <= {cs_s[0], i_CS};
      sck_s <= {sck_s[1:0], i_SCK};
      res_s <= {res_s[0], i_RES};
      mosi_s <= {mosi_s[0], i_MOSI};
      dc_s <= {dc_s[0], i_DC};
      cs_d <= cs;
      o_VALID <= 1'b0;
      o_FRAME_ERR <= 1'b0;
      if (!res_s[1]) begin
        state <= HELD;
        bit_cnt <= '0;
        o_DISPLAY_ON <= 1'b0;
        o_CMD_COUNT <= '0;
        o_DATA_COUNT <= '0;
      end else begin
        case (state)
          IDLE: if (cs_d && !cs) begin
            state <= SHIFT;
            bit_cnt <= '0;
          end
          SHIFT: begin
            if (sck_rise) shreg <= word[N-2:0];
            if (last) begin
              o_DATA <= word;
              o_DC <= dc_s[1];
              o_VALID <= 1'b1;
              if (dc_s[1]) begin
                if (~&o_DATA_COUNT) o_DATA_COUNT <= o_DATA_COUNT + CNT_W'(1);
              end else begin
                if (~&o_CMD_COUNT) o_CMD_COUNT <= o_CMD_COUNT + CNT_W'(1);
                if (N == 8 && word == ON) o_DISPLAY_ON <= 1'b1;
                else if (N == 8 && word == OFF) o_DISPLAY_ON <= 1'b0;
              end
            end
            bit_cnt <= cs ? '0 : nxt_cnt;
            o_FRAME_ERR <= cs && nxt_cnt != '0;
            state <= cs ? IDLE : SHIFT;
          end
          default: begin
            state <= IDLE;
            bit_cnt <= '0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_oled_spi_receiver.sv
// tb_oled_spi_receiver: directed checks of word receive, bursts, frame errors, display reset and saturation
module tb_oled_spi_receiver;
  logic clk = 0, rst = 0, cs = 1, mosi = 0, sck = 1, dc = 0, res = 1;
  logic [7:0] data, data2;
  logic dc_o, valid, ferr, disp, dc_o2, valid2, ferr2, disp2;
  logic [15:0] cmd_cnt, data_cnt;
  logic [1:0] cmd_cnt2, data_cnt2;
  int tests = 0, fails = 0, vcnt = 0, ecnt = 0, strobe_err = 0;
  logic pv = 0, pe = 0;
  logic [7:0] cap[$];

  oled_spi_receiver dut (
    .i_CLK(clk), .i_RST(rst), .i_CS(cs), .i_MOSI(mosi), .i_SCK(sck), .i_DC(dc), .i_RES(res),
    .o_DATA(data), .o_DC(dc_o), .o_VALID(valid), .o_FRAME_ERR(ferr), .o_DISPLAY_ON(disp),
    .o_CMD_COUNT(cmd_cnt), .o_DATA_COUNT(data_cnt));
  oled_spi_receiver #(.N(8), .CNT_W(2)) dut2 (
    .i_CLK(clk), .i_RST(rst), .i_CS(cs), .i_MOSI(mosi), .i_SCK(sck), .i_DC(dc), .i_RES(res),
    .o_DATA(data2), .o_DC(dc_o2), .o_VALID(valid2), .o_FRAME_ERR(ferr2), .o_DISPLAY_ON(disp2),
    .o_CMD_COUNT(cmd_cnt2), .o_DATA_COUNT(data_cnt2));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) begin
      vcnt++;
      cap.push_back(data);
    end
    if (ferr) ecnt++;
    if ((valid && pv) || (ferr && pe)) strobe_err++;
    pv = valid;
    pe = ferr;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_bits(input logic [7:0] w, input int nb, input logic d);
    for (int i = 7; i >= 8 - nb; i--) begin
      sck = 0; mosi = w[i]; dc = d;
      tick(8);
      sck = 1;
      tick(8);
    end
  endtask

  task automatic frame(input logic [7:0] w, input logic d);
    cs = 0;
    tick(8);
    send_bits(w, 8, d);
    cs = 1;
    tick(10);
  endtask

  task automatic test_reset;
    rst = 1;
    tick(3);
    @(negedge clk);
    tests++;
    if ({data, dc_o, valid, ferr, disp, cmd_cnt, data_cnt} !== '0) begin
      fails++; $display("FAIL reset_outputs: got %h required 0", {data, dc_o, valid, ferr, disp, cmd_cnt, data_cnt});
    end
    rst = 0;
    tick(4);
  endtask

  task automatic test_cmd;
    int v0 = vcnt;
    frame(8'hAF, 0);
    tests++;
    if (vcnt - v0 !== 1) begin fails++; $display("FAIL cmd_valid_count: got %0d required 1", vcnt - v0); end
    tests++;
    if (data !== 8'hAF || dc_o !== 0) begin fails++; $display("FAIL cmd_word: got %h/%b required af/0", data, dc_o); end
    tests++;
    if (disp !== 1) begin fails++; $display("FAIL cmd_display_on: got %b required 1", disp); end
    tests++;
    if (cmd_cnt !== 1) begin fails++; $display("FAIL cmd_count: got %0d required 1", cmd_cnt); end
  endtask

  task automatic test_burst;
    logic [7:0] w[3] = '{8'h12, 8'h34, 8'h56};
    int e0 = ecnt;
    cap.delete();
    cs = 0;
    tick(8);
    for (int i = 0; i < 3; i++) send_bits(w[i], 8, 1);
    cs = 1;
    tick(10);
    tests++;
    if (cap.size() !== 3) begin fails++; $display("FAIL burst_strobes: got %0d required 3", cap.size()); end
    for (int i = 0; i < 3 && i < cap.size(); i++) begin
      tests++;
      if (cap[i] !== w[i]) begin fails++; $display("FAIL burst_word%0d: got %h required %h", i, cap[i], w[i]); end
    end
    tests++;
    if (data_cnt !== 3 || dc_o !== 1) begin fails++; $display("FAIL burst_data_count: got %0d/%b required 3/1", data_cnt, dc_o); end
    tests++;
    if (ecnt !== e0) begin fails++; $display("FAIL burst_frame_err: got %0d required 0", ecnt - e0); end
  endtask

  task automatic test_partial;
    int v0 = vcnt, e0 = ecnt;
    cs = 0;
    tick(8);
    send_bits(8'hF0, 5, 0);
    cs = 1;
    tick(10);
    tests++;
    if (ecnt - e0 !== 1) begin fails++; $display("FAIL partial_err: got %0d required 1", ecnt - e0); end
    tests++;
    if (vcnt !== v0) begin fails++; $display("FAIL partial_valid: got %0d required 0", vcnt - v0); end
    frame(8'hAE, 0);
    tests++;
    if (data !== 8'hAE || disp !== 0 || cmd_cnt !== 2 || ecnt - e0 !== 1) begin
      fails++; $display("FAIL partial_recover: got %h/%b/%0d required ae/0/2", data, disp, cmd_cnt);
    end
    v0 = vcnt; e0 = ecnt;
    cs = 0;
    tick(8);
    cs = 1;
    tick(10);
    tests++;
    if (vcnt !== v0 || ecnt !== e0) begin fails++; $display("FAIL empty_frame: got %0d/%0d required 0/0", vcnt - v0, ecnt - e0); end
  endtask

  task automatic test_display_reset;
    int v0, e0;
    frame(8'hAF, 0);
    tests++;
    if (disp !== 1) begin fails++; $display("FAIL dres_setup: got %b required 1", disp); end
    v0 = vcnt; e0 = ecnt;
    res = 0; cs = 0;
    for (int i = 0; i < 10; i++) begin
      sck = ~sck; mosi = i[0];
      tick(1);
    end
    sck = 1; cs = 1;
    tick(2);
    res = 1;
    tick(6);
    tests++;
    if (disp !== 0 || cmd_cnt !== 0 || data_cnt !== 0) begin
      fails++; $display("FAIL dres_clear: got %b/%0d/%0d required 0/0/0", disp, cmd_cnt, data_cnt);
    end
    tests++;
    if (vcnt !== v0 || ecnt !== e0) begin fails++; $display("FAIL dres_strobes: got %0d/%0d required 0/0", vcnt - v0, ecnt - e0); end
  endtask

  task automatic test_rst_mid_word;
    frame(8'h3C, 1);
    cs = 0;
    tick(8);
    send_bits(8'hFF, 4, 1);
    @(negedge clk);
    rst = 1;
    #1;
    tests++;
    if ({data, dc_o, valid, ferr, disp, cmd_cnt, data_cnt} !== '0) begin
      fails++; $display("FAIL rst_async: got %h required 0", {data, dc_o, valid, ferr, disp, cmd_cnt, data_cnt});
    end
    cs = 1;
    tick(3);
    rst = 0;
    tick(4);
    frame(8'hA5, 1);
    tests++;
    if (data !== 8'hA5 || dc_o !== 1 || data_cnt !== 1 || cmd_cnt !== 0) begin
      fails++; $display("FAIL rst_recover: got %h/%b/%0d/%0d required a5/1/1/0", data, dc_o, data_cnt, cmd_cnt);
    end
  endtask

  task automatic test_saturation;
    rst = 1;
    tick(2);
    rst = 0;
    tick(4);
    for (int i = 1; i <= 5; i++) frame(8'(i), 0);
    tests++;
    if (cmd_cnt2 !== 2'd3) begin fails++; $display("FAIL sat_cmd_count: got %0d required 3", cmd_cnt2); end
    tests++;
    if (cmd_cnt !== 5 || data2 !== 8'h05) begin fails++; $display("FAIL sat_wide_count: got %0d/%h required 5/05", cmd_cnt, data2); end
  endtask

  task automatic test_strobes;
    tests++;
    if (strobe_err !== 0) begin fails++; $display("FAIL strobe_width: got %0d double strobes required 0", strobe_err); end
  endtask

  initial begin
    test_reset;
    test_cmd;
    test_burst;
    test_partial;
    test_display_reset;
    test_rst_mid_word;
    test_saturation;
    test_strobes;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
